// File: rtl/scan_sequencer.sv
// scan_sequencer: drives the select code and enables of a 3-to-8 decoder,
// stepping through codes 0..lim with DIV clocks per digit slot.
// Optional feature: define SCAN_BLANK_EN to insert a BLANK_LEN-clock gap
// (decoder disabled, code held) after every slot.
// All outputs come straight from registers.
module scan_sequencer #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned BLANK_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] last_digit,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       e1_low,
    output logic       e2_low,
    output logic       e3,
    output logic       busy,
    output logic       frame_done
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_LEN - 1);
`else
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
`endif

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t      state_q, state_d;
    logic [2:0]  code_q,  code_d;
    logic [15:0] presc_q, presc_d;
    logic [2:0]  lim_q,   lim_d;
    logic        pend_q,  pend_d;
    logic        fd_q,    fd_d;
    logic        advance;
`ifdef SCAN_BLANK_EN
    logic [7:0]  blank_q, blank_d;
`endif

    // Next-state logic: slot/blank timing, code advance, wrap and stop handling.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        presc_d = presc_q;
        lim_d   = lim_q;
        pend_d  = pend_q;
        fd_d    = 1'b0;
        advance = 1'b0;
`ifdef SCAN_BLANK_EN
        blank_d = blank_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = SCAN;
                    code_d  = '0;
                    presc_d = '0;
                    lim_d   = last_digit;
                end
            end
            SCAN: begin
                // A stop seen on the wrap clock itself already counts for that wrap.
                pend_d = pend_q | stop;
                if (presc_q == DIV_LAST) begin
                    presc_d = '0;
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;
                    blank_d = '0;
`else
                    advance = 1'b1;
`endif
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                pend_d = pend_q | stop;
                if (blank_q == BLANK_LAST) begin
                    advance = 1'b1;
                end else begin
                    blank_d = blank_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (code_q == lim_q) begin
                fd_d   = 1'b1;
                code_d = '0;
                if (pend_d) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end else begin
                    state_d = SCAN;
                    lim_d   = last_digit;
                end
            end else begin
                code_d  = code_q + 3'd1;
                state_d = SCAN;
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            presc_q <= '0;
            lim_q   <= '0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            presc_q <= presc_d;
            lim_q   <= lim_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
`ifdef SCAN_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign {c1, c2, c3}           = code_q;
    assign {e1_low, e2_low, e3}   = (state_q == SCAN) ? 3'b001 : 3'b110;
    assign busy                   = (state_q != IDLE);
    assign frame_done             = fd_q;

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving clocks per digit slot (legal range 1..65535).
REQ-002 The block SHALL have parameter BLANK_LEN, default 2, giving clocks per blanking gap (legal range 1..255; used only with SCAN_BLANK_EN).
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port start  input  1  start-scan request, sampled each clock.
REQ-006 The block SHALL have port stop  input  1  stop request, sampled each clock.
REQ-007 The block SHALL have port last_digit  input  3  highest code of the frame (0..7).
REQ-008 The block SHALL have ports c1, c2, c3  output  1 each  select code, c1 = MSB, for the 3-to-8 decoder.
REQ-009 The block SHALL have ports e1_low, e2_low  output  1 each  active-low decoder enables.
REQ-010 The block SHALL have port e3  output  1  active-high decoder enable.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port frame_done  output  1  one-clock pulse at frame end.
REQ-013 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-014 The FSM SHALL have states IDLE, SCAN and BLANK; BLANK exists only with SCAN_BLANK_EN.
REQ-015 Decoder enable SHALL be {e1_low,e2_low,e3}=001 in SCAN only, and 110 in IDLE and BLANK.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-017 In IDLE, start=1 and stop=0 SHALL move the FSM to SCAN at the next edge with code=0, the prescaler cleared and last_digit latched into lim.
REQ-018 In SCAN, the prescaler SHALL count 0..DIV-1, and a slot SHALL end on the clock where the count equals DIV-1, so each code is enabled for exactly DIV clocks.
REQ-019 At slot end with SCAN_BLANK_EN, the FSM SHALL enter BLANK for exactly BLANK_LEN clocks with the code held, then return to SCAN with the code advanced.
REQ-020 At slot end without SCAN_BLANK_EN, the code SHALL advance and SCAN SHALL continue with no gap.
REQ-021 Code advance SHALL be code+1; if code == lim, the code SHALL wrap to 0, lim SHALL reload from last_digit, and frame_done SHALL pulse for one clock coincident with the first clock of the wrapped slot.
REQ-022 last_digit changes mid-frame SHALL have no effect until the next wrap.
REQ-023 When lim=0, code SHALL stay 0 and frame_done SHALL pulse every slot.
REQ-024 stop=1 while busy SHALL set a sticky pending-stop flag; at the next wrap the FSM SHALL go to IDLE instead of slot 0, frame_done SHALL still pulse, and the flag SHALL clear.
REQ-025 stop in IDLE SHALL be ignored; start and stop together in IDLE SHALL keep the FSM in IDLE.
REQ-026 start while busy SHALL be ignored and SHALL NOT clear a pending stop.
REQ-027 With DIV=1, each slot SHALL last exactly one clock.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL go to IDLE and set code=000, {e1_low,e2_low,e3}=110, busy=0, frame_done=0, prescaler=0, lim=0 and pending-stop=0.
REQ-029 rst SHALL take priority over all other inputs, including mid-slot and mid-blank; outputs SHALL reach reset values at the edge that samples rst=1.

Configuration
REQ-030 Macro SCAN_BLANK_EN defined SHALL compile in the BLANK state and BLANK_LEN counter, giving a frame length of (lim+1)*(DIV+BLANK_LEN) clocks.
REQ-031 Macro SCAN_BLANK_EN undefined SHALL remove all BLANK logic, giving a frame length of (lim+1)*DIV clocks, with the decoder enabled continuously while busy.

Verification
REQ-032 Without the macro, DIV=4, last_digit=3, one start pulse: codes 0,1,2,3,0 each held 4 clocks with enable 001, and frame_done high on the first clock of the second code-0 slot.
REQ-033 With the macro, DIV=4, BLANK_LEN=2, last_digit=1: pattern SCAN0 x4, BLANK x2 (enable 110, code 0), SCAN1 x4, BLANK x2, SCAN0, giving a 12-clock frame.
REQ-034 stop pulse during code 1 of a 4-digit frame: codes 2 and 3 still scanned, then IDLE with busy=0, enable 110, code 000, and exactly one frame_done.
REQ-035 last_digit changed 3->5 during code 2: current frame wraps after 3, and the next frame scans 0..5.
REQ-036 rst asserted during BLANK (macro) and during SCAN with DIV=1: all outputs at reset values on the next edge; start after rst release: code 0 with enable 001 one clock later.
REQ-037 start and stop together in IDLE: busy stays 0; start while busy: no change in code or slot timing.
